// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Holds the pointer-width function and the default flag thresholds.
package fifo_pkg;

    localparam int unsigned AE_LEVEL_DEFAULT  = 2;
    localparam int unsigned AF_MARGIN_DEFAULT = 2;

    // Ceiling log2; clog2(1) is 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int unsigned width = 4,
    parameter int unsigned depth = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(depth)-1:0]   waddr,
    input  logic [width-1:0]          wdata,
    input  logic [clog2(depth)-1:0]   raddr,
    output logic [width-1:0]          rdata
);

    logic [width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with wrap-bit pointers, threshold flags, sticky error
// flags and a choice of first-word-fall-through or registered read data.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned bw       = 4,
    parameter int unsigned simd     = 1,
    parameter int unsigned depth    = 16,
    parameter int unsigned af_level = depth - AF_MARGIN_DEFAULT,
    parameter int unsigned ae_level = AE_LEVEL_DEFAULT,
    parameter int unsigned fwft     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [simd*bw-1:0]       in,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     clr_err,
    output logic [simd*bw-1:0]       out,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [clog2(depth):0]    o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int unsigned W  = simd * bw;
    localparam int unsigned AW = clog2(depth);
    localparam int unsigned PW = AW + 1;

    localparam logic [PW-1:0] AF_LEVEL = PW'(af_level);
    localparam logic [PW-1:0] AE_LEVEL = PW'(ae_level);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] count;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;
    logic [W-1:0]  rd_data;

    // Full and empty differ only in the wrap bit.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count   = wr_ptr_q - rd_ptr_q;

    assign o_count        = count;
    assign o_almost_full  = (count >= AF_LEVEL);
    assign o_almost_empty = (count <= AE_LEVEL);

    // A write into a full FIFO is allowed when a read frees the head slot.
    assign rd_acc = rd && !o_empty;
    assign wr_acc = wr && (!o_full || rd_acc);

    assign overflow_d  = (wr && !wr_acc) || (overflow_q && !clr_err);
    assign underflow_d = (rd && !rd_acc) || (underflow_q && !clr_err);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

    // Gating with reset keeps a write from landing while reset is asserted.
    fifo_regfile #(
        .width (W),
        .depth (depth)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_acc && reset),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    generate
        if (fwft != 0) begin : g_fwft
            assign out = rd_data;
        end else begin : g_reg
            logic [W-1:0] out_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    out_q <= '0;
                end else if (rd_acc) begin
                    out_q <= rd_data;
                end
            end

            assign out = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomized and directed bench for fifo_sync_param: a queue model predicts
// data and flags, a negedge monitor compares the DUT against it.
module tb_fifo_sync_param;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset, wr, rd, clr_err;
    logic [3:0] in, out;
    logic       o_full, o_empty, o_almost_full, o_almost_empty, o_overflow, o_underflow;
    logic [4:0] o_count;

    logic       r_reset, r_wr, r_rd;
    logic [3:0] r_in, r_out;
    logic       r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic [4:0] r_count;

    int n_vec = 0;
    int n_err = 0;

    // Model state: contents queue plus expected status visible this cycle.
    logic [3:0] sb_q[$];
    int         m_cnt;
    logic       m_ovf, m_unf;
    int         e_cnt;
    logic       e_ovf, e_unf, e_rd_ok;
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param #(.bw(4), .simd(1), .depth(DEPTH), .fwft(1)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .clr_err(clr_err),
        .out(out), .o_full(o_full), .o_empty(o_empty), .o_almost_full(o_almost_full),
        .o_almost_empty(o_almost_empty), .o_count(o_count),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    fifo_sync_param #(.bw(4), .simd(1), .depth(DEPTH), .fwft(0)) dut_r (
        .clk(clk), .reset(r_reset), .in(r_in), .wr(r_wr), .rd(r_rd), .clr_err(1'b0),
        .out(r_out), .o_full(r_full), .o_empty(r_empty), .o_almost_full(r_af),
        .o_almost_empty(r_ae), .o_count(r_count),
        .o_overflow(r_ovf), .o_underflow(r_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic cycle(input logic w, input logic r, input logic c, input logic [3:0] d);
        logic rd_ok, wr_ok;
        @(posedge clk);
        #2;
        wr = w; rd = r; clr_err = c; in = d;
        e_cnt = m_cnt; e_ovf = m_ovf; e_unf = m_unf;
        rd_ok = r && (m_cnt > 0);
        wr_ok = w && ((m_cnt < DEPTH) || rd_ok);
        e_rd_ok = rd_ok;
        if (wr_ok) sb_q.push_back(d);
        m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
        m_ovf = (w && !wr_ok) || (m_ovf && !c);
        m_unf = (r && !rd_ok) || (m_unf && !c);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(o_count), e_cnt);
            chk("full", 32'(o_full), 32'(e_cnt == DEPTH));
            chk("empty", 32'(o_empty), 32'(e_cnt == 0));
            chk("almost_full", 32'(o_almost_full), 32'(e_cnt >= DEPTH - 2));
            chk("almost_empty", 32'(o_almost_empty), 32'(e_cnt <= 2));
            chk("overflow", 32'(o_overflow), 32'(e_ovf));
            chk("underflow", 32'(o_underflow), 32'(e_unf));
            if (e_rd_ok) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rdata: read with no expected entry at %0t", $time);
                end else begin
                    chk("rdata", 32'(out), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [3:0] d;
        reset = 1'b0; wr = 0; rd = 0; clr_err = 0; in = '0;
        r_reset = 1'b0; r_wr = 0; r_rd = 0; r_in = '0;
        m_cnt = 0; m_ovf = 0; m_unf = 0;
        e_cnt = 0; e_ovf = 0; e_unf = 0; e_rd_ok = 0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_count", 32'(o_count), 0);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_full", 32'(o_full), 0);
        chk("rst_ae", 32'(o_almost_empty), 1);
        chk("rst_af", 32'(o_almost_full), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        mon_en = 1'b1;

        // Fill with 0..15.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 4'(i));
        cycle(0, 0, 0, 0);
        chk("fill_full", 32'(o_full), 1);
        chk("fill_count", 32'(o_count), 16);

        // Rejected write while full.
        cycle(1, 0, 0, 4'hA);
        cycle(0, 0, 0, 0);
        chk("ovf_set", 32'(o_overflow), 1);
        chk("ovf_head", 32'(out), 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("ovf_clr", 32'(o_overflow), 0);

        // Read and write together while full.
        cycle(1, 1, 0, 4'h5);
        cycle(0, 0, 0, 0);
        chk("rw_full_out", 32'(out), 1);
        chk("rw_full_count", 32'(o_count), 16);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("rw_full_last", 32'(out), 5);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("drain_empty", 32'(o_empty), 1);

        // Underflow, then read and write together while empty.
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("unf_set", 32'(o_underflow), 1);
        chk("unf_count", 32'(o_count), 0);
        cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 4'h9);
        cycle(0, 0, 0, 0);
        chk("rw_empty_count", 32'(o_count), 1);
        chk("rw_empty_unf", 32'(o_underflow), 1);
        cycle(0, 1, 1, 0);

        // Interleaved pairs carry the pointers across the wrap.
        for (int i = 0; i < 3; i++) begin
            d = 4'($urandom_range(0, 15));
            cycle(1, 0, 0, d);
        end
        for (int i = 0; i < 40; i++) begin
            d = 4'($urandom_range(0, 15));
            cycle(1, 0, 0, d);
            cycle(0, 1, 0, 0);
        end

        // Random traffic, write-biased then read-biased.
        for (int i = 0; i < 400; i++) begin
            d = 4'($urandom_range(0, 15));
            if (i < 200)
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7) == 0, d);
            else
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7) == 0, d);
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        mon_en = 1'b0;

        // Registered-read instance with an asynchronous reset mid-stream.
        @(negedge clk);
        r_reset = 1'b1;
        @(posedge clk); #2; r_wr = 1; r_in = 4'h3;
        @(posedge clk); #2; r_wr = 0; r_rd = 1;
        @(posedge clk); #2; r_rd = 0;
        chk("reg_out3", 32'(r_out), 3);
        r_wr = 1; r_in = 4'h3;
        @(posedge clk); #2; r_wr = 0;
        chk("reg_count1", 32'(r_count), 1);
        r_reset = 1'b0;
        #1;
        chk("async_count", 32'(r_count), 0);
        chk("async_out", 32'(r_out), 0);
        chk("async_empty", 32'(r_empty), 1);
        @(negedge clk);
        r_reset = 1'b1;
        @(posedge clk); #2; r_wr = 1; r_in = 4'h7;
        @(posedge clk); #2; r_wr = 0; r_rd = 1;
        chk("reg_out_before", 32'(r_out), 0);
        @(posedge clk); #2; r_rd = 0;
        chk("reg_out7", 32'(r_out), 7);
        chk("reg_count0", 32'(r_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
